// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
//   Shared definitions for the ALU operation sequencer:
//   - state_t          : sequencer phases IDLE -> READ -> EXEC -> WB
//   - field positions  : bit ranges of the 32-bit instruction word
//   - ALU_* constants  : operation codes carried in the op field
//   - sext15()         : 15-bit immediate to 32-bit sign extension
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    // Instruction word layout
    localparam int OP_HI       = 31;
    localparam int OP_LO       = 28;
    localparam int IMM_SEL_BIT = 27;
    localparam int RD_HI       = 26;
    localparam int RD_LO       = 23;
    localparam int RS1_HI      = 22;
    localparam int RS1_LO      = 19;
    localparam int RS2_HI      = 18;
    localparam int RS2_LO      = 15;
    localparam int IMM_HI      = 14;
    localparam int IMM_LO      = 0;

    // ALU operation codes; the sequencer forwards op unchanged, so codes
    // 11..15 are simply passed through to the external ALU.
    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLL   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_SLT   = 4'd8;
    localparam logic [3:0] ALU_SLTU  = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    // Replicate bit 14 into the upper 17 bits.
    function automatic logic [31:0] sext15(input logic [14:0] imm);
        return {{17{imm[14]}}, imm};
    endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// alu_seq_decode
//   Purely combinational field splitter and B-operand selector for the
//   latched instruction word.
//   Ports:
//     instr      in  32  latched instruction word
//     rf_rdata_b in  32  register-file read data for rs2
//     op         out 4   ALU operation select
//     rd         out 4   destination register
//     rs1 / rs2  out 4   source registers
//     operand_b  out 32  sign-extended immediate or rf_rdata_b
module alu_seq_decode
    import alu_seq_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] rf_rdata_b,
    output logic [3:0]  op,
    output logic [3:0]  rd,
    output logic [3:0]  rs1,
    output logic [3:0]  rs2,
    output logic [31:0] operand_b
);

    logic        imm_sel_s;
    logic [14:0] imm_s;

    assign op        = instr[OP_HI:OP_LO];
    assign imm_sel_s = instr[IMM_SEL_BIT];
    assign rd        = instr[RD_HI:RD_LO];
    assign rs1       = instr[RS1_HI:RS1_LO];
    assign rs2       = instr[RS2_HI:RS2_LO];
    assign imm_s     = instr[IMM_HI:IMM_LO];

    // B operand: immediate form or second register operand.
    always_comb begin
        operand_b = rf_rdata_b;
        if (imm_sel_s) begin
            operand_b = sext15(imm_s);
        end else begin
            operand_b = rf_rdata_b;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Multi-cycle controller: accepts one instruction word, reads the
//   register file, drives the external combinational ALU, and writes the
//   result back. One instruction in flight; phases IDLE/READ/EXEC/WB.
//   Ports:
//     clk, rst_n                  clock, asynchronous active-low reset
//     instr_valid/instr_ready     instruction handshake
//     instr                       32-bit instruction word
//     rf_raddr_a/b, rf_rdata_a/b  register-file read (1-cycle latency)
//     rf_we, rf_waddr, rf_wdata   register-file write port
//     alu_a, alu_b, alu_op        ALU operands and operation
//     alu_result                  combinational ALU result
//     done                        one-cycle retire pulse (WB cycle)
//     result                      last retired result
//     retired                     wrapping retired-instruction count
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RF_AW  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    output logic [RF_AW-1:0]  rf_raddr_a,
    output logic [RF_AW-1:0]  rf_raddr_b,
    input  logic [DATA_W-1:0] rf_rdata_a,
    input  logic [DATA_W-1:0] rf_rdata_b,
    output logic              rf_we,
    output logic [RF_AW-1:0]  rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [CNT_W-1:0]  retired
);

    state_t              state_r;
    logic [31:0]         instr_r;     // latched instruction word
    logic [DATA_W-1:0]   res_r;       // latched ALU result
    logic                ready_r;
    logic                we_r;
    logic                done_r;
    logic [DATA_W-1:0]   result_r;
    logic [CNT_W-1:0]    retired_r;

    logic [3:0]          op_s;
    logic [3:0]          rd_s;
    logic [3:0]          rs1_s;
    logic [3:0]          rs2_s;
    logic [31:0]         operand_b_s;

    alu_seq_decode u_decode (
        .instr      (instr_r),
        .rf_rdata_b (rf_rdata_b),
        .op         (op_s),
        .rd         (rd_s),
        .rs1        (rs1_s),
        .rs2        (rs2_s),
        .operand_b  (operand_b_s)
    );

    // Datapath outputs follow the latched word in every state; rf_we alone
    // marks the cycle in which they are meaningful for a write.
    assign rf_raddr_a  = rs1_s;
    assign rf_raddr_b  = rs2_s;
    assign alu_a       = rf_rdata_a;
    assign alu_b       = operand_b_s;
    assign alu_op      = op_s;
    assign rf_waddr    = rd_s;
    assign rf_wdata    = res_r;
    assign instr_ready = ready_r;
    assign rf_we       = we_r;
    assign done        = done_r;
    assign result      = result_r;
    assign retired     = retired_r;

    // Sequencer FSM with registered handshake, write-enable and retire outputs.
    // Retire bookkeeping (done, result, retired, rf_we) is loaded on the
    // EXEC->WB edge so all of it becomes visible together in the WB cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            instr_r   <= 32'd0;
            res_r     <= {DATA_W{1'b0}};
            ready_r   <= 1'b1;
            we_r      <= 1'b0;
            done_r    <= 1'b0;
            result_r  <= {DATA_W{1'b0}};
            retired_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    we_r   <= 1'b0;
                    done_r <= 1'b0;
                    if (instr_valid && ready_r) begin
                        instr_r <= instr;
                        ready_r <= 1'b0;
                        state_r <= READ;
                    end else begin
                        ready_r <= 1'b1;
                        state_r <= IDLE;
                    end
                end
                READ: begin
                    // Addresses are presented this cycle; data arrives in EXEC.
                    ready_r <= 1'b0;
                    we_r    <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= EXEC;
                end
                EXEC: begin
                    res_r     <= alu_result;
                    result_r  <= alu_result;
                    we_r      <= (rd_s != 4'd0);
                    done_r    <= 1'b1;
                    retired_r <= retired_r + CNT_W'(1);
                    ready_r   <= 1'b0;
                    state_r   <= WB;
                end
                WB: begin
                    we_r    <= 1'b0;
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= IDLE;
                end
                default: begin
                    we_r    <= 1'b0;
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
